// File: rtl/serial_comparator_n.sv
// serial_comparator_n: bit-serial MSB-first magnitude comparator (unsigned or two's-complement)
module serial_comparator_n #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED     = 1'b0,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 Y,
  output logic [$clog2(WIDTH+1)-1:0] cycles
);
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] k_q, k_d, cyc_q, cyc_d;
  logic dec_q, dec_d, gt_q, gt_d, diff, bit_gt, last;
  logic [2:0] y_q, y_d;
  always_comb begin
    diff    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & ~dec_q;
    // a set sign bit marks the smaller operand in two's complement
    bit_gt  = (SIGNED && k_q == '0) ? b_q[WIDTH-1] : a_q[WIDTH-1];
    last    = k_q == CW'(WIDTH-1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    dec_d   = dec_q;
    gt_d    = gt_q;
    y_d     = y_q;
    cyc_d   = cyc_q;
    if (state_q == IDLE && start) begin
      a_d     = A;
      b_d     = B;
      k_d     = '0;
      dec_d   = 1'b0;
      gt_d    = 1'b0;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      a_d   = a_q << 1;
      b_d   = b_q << 1;
      k_d   = k_q + 1'b1;
      dec_d = dec_q | diff;
      gt_d  = diff ? bit_gt : gt_q;
      if (last || (EARLY_EXIT && diff)) begin
        state_d = DONE;
        y_d     = dec_d ? {gt_d, 1'b0, ~gt_d} : 3'b010;
        cyc_d   = k_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      y_q     <= 3'b000;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      dec_q   <= dec_d;
      gt_q    <= gt_d;
      y_q     <= y_d;
      cyc_q   <= cyc_d;
    end
  end
  assign busy   = state_q == SCAN;
  assign done   = state_q == DONE;
  assign Y      = y_q;
  assign cycles = cyc_q;
endmodule

// File: tb/tb_serial_comparator_n.sv
// tb_serial_comparator_n: scoreboard bench over three parameterisations driven in lockstep
module tb_serial_comparator_n;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] busy_w, done_w;
  logic [2:0][2:0] y_w, last_y;
  logic [2:0][3:0] c_w, last_c;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [2:0][2:0] y;
    logic [2:0][3:0] c;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  serial_comparator_n #(.WIDTH(W), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u0 (.clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .busy(busy_w[0]), .done(done_w[0]), .Y(y_w[0]), .cycles(c_w[0]));
  serial_comparator_n #(.WIDTH(W), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .busy(busy_w[1]), .done(done_w[1]), .Y(y_w[1]), .cycles(c_w[1]));
  serial_comparator_n #(.WIDTH(W), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u2 (.clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .busy(busy_w[2]), .done(done_w[2]), .Y(y_w[2]), .cycles(c_w[2]));
  function automatic logic [6:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input bit sgn, input bit early);
    for (int i = W-1; i >= 0; i--) begin
      if (ma[i] != mb[i]) begin
        logic gt;
        gt = (sgn && i == W-1) ? ~ma[i] : ma[i];
        return {gt ? 3'b100 : 3'b001, early ? 4'(W-i) : 4'(W)};
      end
    end
    return {3'b010, 4'(W)};
  endfunction
  function automatic exp_t expect_all(input logic [W-1:0] ma, input logic [W-1:0] mb);
    exp_t e;
    logic [6:0] m;
    for (int d = 0; d < 3; d++) begin
      m = model(ma, mb, d == 1, d != 2);
      e.y[d] = m[6:4];
      e.c[d] = m[3:0];
    end
    return e;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({busy_w[d], done_w[d], y_w[d], c_w[d]} !== 9'd0) begin
        failures++;
        $display("FAIL reset dut%0d busy=%b done=%b Y=%b cycles=%0d required all zero", d, busy_w[d], done_w[d], y_w[d], c_w[d]);
      end
    end
    rst = 1'b0;
    last_y = '0;
    last_c = '0;
  endtask
  task automatic test_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit restart, input string name);
    exp_t e;
    bit [2:0] seen;
    sb.push_back(expect_all(ta, tb_v));
    e = sb[0];
    seen = '0;
    a = ta;
    b = tb_v;
    start = 1'b1;
    for (int j = 1; j <= W+2; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (done_w[d] !== (j == int'(e.c[d]) + 1) || busy_w[d] !== (j <= int'(e.c[d]))) begin
          failures++;
          $display("FAIL %s ctrl dut%0d cyc%0d done=%b busy=%b required done=%b busy=%b", name, d, j,
                   done_w[d], busy_w[d], j == int'(e.c[d]) + 1, j <= int'(e.c[d]));
        end
        if (done_w[d] === 1'b1) begin
          seen[d] = 1'b1;
          last_y[d] = e.y[d];
          last_c[d] = e.c[d];
        end
        checks++;
        if (y_w[d] !== last_y[d] || c_w[d] !== last_c[d]) begin
          failures++;
          $display("FAIL %s result dut%0d cyc%0d Y=%b cycles=%0d required Y=%b cycles=%0d", name, d, j,
                   y_w[d], c_w[d], last_y[d], last_c[d]);
        end
      end
      start = restart && j == 1;
      a = (restart && j == 1) ? 8'hFF : W'($urandom);
      b = (restart && j == 1) ? 8'h00 : W'($urandom);
    end
    start = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (seen !== 3'b111) begin
      failures++;
      $display("FAIL %s timeout seen=%b required 111", name, seen);
    end
  endtask
  task automatic test_reset_abort();
    a = 8'hA5;
    b = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({busy_w[d], done_w[d], y_w[d], c_w[d]} !== 9'd0) begin
        failures++;
        $display("FAIL abort dut%0d busy=%b done=%b Y=%b cycles=%0d required all zero", d, busy_w[d], done_w[d], y_w[d], c_w[d]);
      end
    end
    for (int j = 0; j < W+2; j++) begin
      @(negedge clk);
      checks++;
      if (done_w !== 3'b000 || busy_w !== 3'b000) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d done=%b busy=%b required 000", j, done_w, busy_w);
      end
    end
    last_y = '0;
    last_c = '0;
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int prev[3];
    int cnt[3];
    sb.push_back(expect_all(8'h80, 8'h7F));
    e = sb[0];
    for (int d = 0; d < 3; d++) begin
      prev[d] = -1;
      cnt[d] = 0;
    end
    a = 8'h80;
    b = 8'h7F;
    start = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_w[d] === 1'b1) begin
          checks++;
          if (y_w[d] !== e.y[d] || c_w[d] !== e.c[d] || (prev[d] >= 0 && j - prev[d] != int'(e.c[d]) + 2)) begin
            failures++;
            $display("FAIL b2b dut%0d cyc%0d Y=%b cycles=%0d gap=%0d required Y=%b cycles=%0d gap=%0d", d, j,
                     y_w[d], c_w[d], j - prev[d], e.y[d], e.c[d], int'(e.c[d]) + 2);
          end
          prev[d] = j;
          cnt[d]++;
        end
      end
    end
    start = 1'b0;
    repeat (W+3) @(negedge clk);
    void'(sb.pop_front());
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (cnt[d] < 2) begin
        failures++;
        $display("FAIL b2b_count dut%0d done pulses=%0d required >=2", d, cnt[d]);
      end
    end
    last_y = e.y;
    last_c = e.c;
  endtask
  initial begin
    test_reset();
    test_compare(8'hA5, 8'hA5, 1'b0, "equal");
    test_compare(8'h80, 8'h7F, 1'b0, "msb_diff");
    test_compare(8'h80, 8'h01, 1'b0, "sign");
    test_compare(8'h03, 8'h02, 1'b0, "lsb_diff");
    test_compare(8'h10, 8'h20, 1'b1, "ignore_start");
    test_compare(8'h00, 8'hFF, 1'b0, "zero_vs_ff");
    test_compare(8'h7F, 8'hFF, 1'b0, "pos_vs_neg");
    for (int i = 0; i < 6; i++) test_compare(W'($urandom), W'($urandom), 1'b0, "random");
    test_reset_abort();
    test_compare(8'h3C, 8'hC3, 1'b0, "after_abort");
    test_back_to_back();
    test_compare(8'h55, 8'h54, 1'b0, "after_b2b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
